// File: rtl/mem_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter_if
//  Description : Shared dcache request/response port. The master side is
//                the arbiter and drives the request. The slave side is the
//                dcache and drives ready and the response.
//  Signals     : dc_req_valid/we/addr/wdata/wstrb  master -> slave
//                dc_req_ready, dc_resp_valid/rdata slave  -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      dc_req_valid;
    logic                      dc_req_ready;
    logic                      dc_req_we;
    logic [ADDR_WIDTH-1:0]     dc_req_addr;
    logic [DATA_WIDTH-1:0]     dc_req_wdata;
    logic [DATA_WIDTH/8-1:0]   dc_req_wstrb;
    logic                      dc_resp_valid;
    logic [DATA_WIDTH-1:0]     dc_resp_rdata;

    modport master (
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
        input  dc_req_ready, dc_resp_valid, dc_resp_rdata
    );

    modport slave (
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_wstrb,
        output dc_req_ready, dc_resp_valid, dc_resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_req_arbiter
//  Description : Sequences the two issue lanes' load/store requests onto the
//                single shared dcache port. Both lanes are captured together
//                and issued to the dcache strictly lane 0 first, with at most
//                one request outstanding. pause_req holds the pipeline until
//                every response is back. Handles flush-abort and draining of
//                an already accepted request. A sticky watchdog flags
//                responses that take too long.
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                flush           pipeline flush for the mem slot
//                lane_valid/we/addr/wdata/wstrb   per-lane request inputs
//                lane_done       one-cycle completion pulse per lane
//                lane_rdata      load data, held until overwritten
//                pause_req       stall request to ctrl
//                dcache          shared dcache port (master modport)
//                timeout_err     sticky watchdog flag
//  Revision    : 1.0  initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          flush,
    input  wire logic [1:0]                    lane_valid,
    input  wire logic [1:0]                    lane_we,
    input  wire logic [1:0][ADDR_WIDTH-1:0]    lane_addr,
    input  wire logic [1:0][DATA_WIDTH-1:0]    lane_wdata,
    input  wire logic [1:0][DATA_WIDTH/8-1:0]  lane_wstrb,
    output logic      [1:0]                    lane_done,
    output logic      [1:0][DATA_WIDTH-1:0]    lane_rdata,
    output logic                               pause_req,
    mem_req_arbiter_if.master                  dcache,
    output logic                               timeout_err
);

    localparam int         c_STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] c_WD_LIMIT   = TIMEOUT_CYCLES[7:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured request set
    logic [1:0]                    r_pending;
    logic [1:0]                    r_we;
    logic [1:0][ADDR_WIDTH-1:0]    r_addr;
    logic [1:0][DATA_WIDTH-1:0]    r_wdata;
    logic [1:0][c_STRB_WIDTH-1:0]  r_wstrb;
    logic [1:0][DATA_WIDTH-1:0]    r_rdata;

    // Watchdog
    logic [7:0]                    r_wd_cnt;
    logic                          r_timeout_err;

    logic w_capture;
    logic w_cur;
    logic w_in_req;
    logic w_in_wait;
    logic w_waiting;
    logic w_rdata_we;
    logic w_wd_entry;
    logic w_wd_tick;

    assign w_capture = (r_state == ST_IDLE) && (|lane_valid) && !flush;
    // Lane currently being served; only meaningful in REQx/WAITx.
    assign w_cur     = (r_state == ST_REQ1) || (r_state == ST_WAIT1);
    assign w_in_req  = (r_state == ST_REQ0) || (r_state == ST_REQ1);
    assign w_in_wait = (r_state == ST_WAIT0) || (r_state == ST_WAIT1);
    assign w_waiting = w_in_wait || (r_state == ST_DRAIN);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Flush takes priority over every other condition.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rdata_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_next = lane_valid[0] ? ST_REQ0 : ST_REQ1;
                end
            end
            ST_REQ0, ST_REQ1: begin
                if (flush) begin
                    // Once accepted, the dcache still owes us a response.
                    w_state_next = dcache.dc_req_ready ? ST_DRAIN : ST_IDLE;
                end else if (dcache.dc_req_ready) begin
                    w_state_next = (r_state == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                end
            end
            ST_WAIT0, ST_WAIT1: begin
                if (flush) begin
                    w_state_next = dcache.dc_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (dcache.dc_resp_valid) begin
                    w_rdata_we = !r_we[w_cur];
                    if (!w_cur && r_pending[1]) begin
                        w_state_next = ST_REQ1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (dcache.dc_resp_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture and load-data return
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_we      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_capture) begin
            r_pending <= lane_valid;
            r_we      <= lane_we;
            r_addr    <= lane_addr;
            r_wdata   <= lane_wdata;
            r_wstrb   <= lane_wstrb;
        end
    end

    // Load data is not cleared on capture; it is only replaced by a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rdata_we) begin
            r_rdata[w_cur] <= dcache.dc_resp_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Watchdog: restarts on every entry into a response-waiting state, counts
    // response-less waiting cycles, and saturates at the limit.
    // ------------------------------------------------------------------------
    assign w_wd_entry = ((w_state_next == ST_WAIT0) || (w_state_next == ST_WAIT1) ||
                         (w_state_next == ST_DRAIN)) && (w_state_next != r_state);
    assign w_wd_tick  = w_waiting && !dcache.dc_resp_valid && !w_wd_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_wd_entry) begin
            r_wd_cnt <= '0;
        end else if (w_wd_tick && (r_wd_cnt != c_WD_LIMIT)) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
            if ((r_wd_cnt + 8'd1) == c_WD_LIMIT) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Payload is zeroed when no request is presented so the bus is
    // quiet outside REQx.
    // ------------------------------------------------------------------------
    assign dcache.dc_req_valid = w_in_req;
    assign dcache.dc_req_we    = w_in_req ? r_we[w_cur]    : 1'b0;
    assign dcache.dc_req_addr  = w_in_req ? r_addr[w_cur]  : '0;
    assign dcache.dc_req_wdata = w_in_req ? r_wdata[w_cur] : '0;
    assign dcache.dc_req_wstrb = w_in_req ? r_wstrb[w_cur] : '0;

    assign pause_req   = w_capture || w_in_req || w_waiting;
    assign lane_done   = (r_state == ST_DONE) ? (r_pending & {2{!flush}}) : 2'b00;
    assign lane_rdata  = r_rdata;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_arbiter
//  Description : Self-checking bench for mem_req_arbiter. Directed vector
//                table, hand-written flush/timeout/reset sequences and
//                randomized traffic, all compared against a transaction-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  flush;
    logic [1:0]            lane_valid;
    logic [1:0]            lane_we;
    logic [1:0][AW-1:0]    lane_addr;
    logic [1:0][DW-1:0]    lane_wdata;
    logic [1:0][SW-1:0]    lane_wstrb;
    logic [1:0]            lane_done;
    logic [1:0][DW-1:0]    lane_rdata;
    logic                  pause_req;
    logic                  timeout_err;

    mem_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dcache ();

    mem_req_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .lane_valid  (lane_valid),
        .lane_we     (lane_we),
        .lane_addr   (lane_addr),
        .lane_wdata  (lane_wdata),
        .lane_wstrb  (lane_wstrb),
        .lane_done   (lane_done),
        .lane_rdata  (lane_rdata),
        .pause_req   (pause_req),
        .dcache      (dcache),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: phase 0 idle, 1 issuing lane m_cur, 2 awaiting lane
    // m_cur's response, 3 draining an aborted request, 4 reporting completion.
    // ------------------------------------------------------------------------
    int                  m_ph;
    int                  m_cur;
    int                  m_cnt;
    logic                m_err;
    logic [1:0]          m_mask;
    logic [1:0]          m_we;
    logic [1:0][AW-1:0]  m_addr;
    logic [1:0][DW-1:0]  m_wdata;
    logic [1:0][SW-1:0]  m_wstrb;
    logic [1:0][DW-1:0]  m_rdata;

    task automatic model_reset();
        m_ph = 0; m_cur = 0; m_cnt = 0; m_err = 1'b0;
        m_mask = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0;
    endtask

    task automatic wd_tick();
        if (m_cnt < TO) m_cnt++;
        if (m_cnt == TO) m_err = 1'b1;
    endtask

    task automatic model_update();
        case (m_ph)
            0: if (|lane_valid && !flush) begin
                m_mask = lane_valid; m_we = lane_we; m_addr = lane_addr;
                m_wdata = lane_wdata; m_wstrb = lane_wstrb;
                m_cur = lane_valid[0] ? 0 : 1;
                m_ph = 1;
            end
            1: if (flush) begin
                if (dcache.dc_req_ready) begin m_ph = 3; m_cnt = 0; end
                else m_ph = 0;
            end else if (dcache.dc_req_ready) begin
                m_ph = 2; m_cnt = 0;
            end
            2: if (flush) begin
                if (dcache.dc_resp_valid) m_ph = 0;
                else begin m_ph = 3; m_cnt = 0; end
            end else if (dcache.dc_resp_valid) begin
                if (!m_we[m_cur]) m_rdata[m_cur] = dcache.dc_resp_rdata;
                if (m_cur == 0 && m_mask[1]) begin m_cur = 1; m_ph = 1; end
                else m_ph = 4;
            end else begin
                wd_tick();
            end
            3: if (dcache.dc_resp_valid) m_ph = 0; else wd_tick();
            default: m_ph = 0;
        endcase
    endtask

    task automatic check_model();
        logic       v;
        logic [1:0] d;
        v = (m_ph == 1);
        d = (m_ph == 4) ? (m_mask & {2{!flush}}) : 2'b00;
        chk("req_valid", dcache.dc_req_valid, v);
        chk("req_we",    dcache.dc_req_we,    v ? m_we[m_cur]    : 1'b0);
        chk("req_addr",  dcache.dc_req_addr,  v ? m_addr[m_cur]  : '0);
        chk("req_wdata", dcache.dc_req_wdata, v ? m_wdata[m_cur] : '0);
        chk("req_wstrb", dcache.dc_req_wstrb, v ? m_wstrb[m_cur] : '0);
        chk("pause_req", pause_req,
            ((m_ph == 0) && (|lane_valid) && !flush) || (m_ph >= 1 && m_ph <= 3));
        chk("lane_done",   lane_done,   d);
        chk("lane_rdata",  lane_rdata,  m_rdata);
        chk("timeout_err", timeout_err, m_err);
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        lane_valid = '0; flush = 1'b0;
        dcache.dc_req_ready = 1'b0; dcache.dc_resp_valid = 1'b0; dcache.dc_resp_rdata = '0;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [1:0]  lv;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        fl;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ev;
        logic [31:0] ea;
        logic        ep;
        logic [1:0]  ed;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] lv, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic fl, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic ev,
                                input logic [31:0] ea, input logic ep,
                                input logic [1:0] ed);
        vec_t r;
        r.lv = lv; r.we = we; r.a0 = a0; r.a1 = a1; r.fl = fl; r.rdy = rdy;
        r.rv = rv; r.rd = rd; r.ev = ev; r.ea = ea; r.ep = ep; r.ed = ed;
        return r;
    endfunction

    vec_t vq[$];

    initial begin
        // Lane 0 load to 0x1000, ready at once, response two cycles after ready
        vq.push_back(mk(2'b01, 2'b00, 32'h1000, 32'h0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h1000, 32'h0, 0, 1, 0, 32'h0,        1, 32'h1000, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h1000, 32'h0, 0, 0, 0, 32'h0,        0, 32'h0,    1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h1000, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,    1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h1000, 32'h0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 2'b01));
        vq.push_back(mk(2'b00, 2'b00, 32'h1000, 32'h0, 0, 0, 0, 32'h0,        0, 32'h0,    0, 2'b00));
        // Lane 1 load to 0x3000 with ready held low for 3 cycles
        vq.push_back(mk(2'b10, 2'b00, 32'h0, 32'h3000, 0, 0, 0, 32'h0,        0, 32'h0,    1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 0, 0, 32'h0,        1, 32'h3000, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 0, 0, 32'h0,        1, 32'h3000, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 0, 0, 32'h0,        1, 32'h3000, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 1, 0, 32'h0,        1, 32'h3000, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 0, 1, 32'h13572468, 0, 32'h0,    1, 2'b00));
        vq.push_back(mk(2'b00, 2'b00, 32'h0, 32'h3000, 0, 0, 0, 32'h0,        0, 32'h0,    0, 2'b10));
        // Both lanes: load 0x10 then store 0x20, zero-wait dcache
        vq.push_back(mk(2'b11, 2'b10, 32'h10, 32'h20, 0, 0, 0, 32'h0,        0, 32'h0,  1, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 1, 0, 32'h0,        1, 32'h10, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 1, 32'h11111111, 0, 32'h0,  1, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 1, 0, 32'h0,        1, 32'h20, 1, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 1, 32'h22222222, 0, 32'h0,  1, 2'b00));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 0, 32'h0,        0, 32'h0,  0, 2'b11));
        vq.push_back(mk(2'b00, 2'b10, 32'h10, 32'h20, 0, 0, 0, 32'h0,        0, 32'h0,  0, 2'b00));
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle_inputs();
        lane_we = '0; lane_addr = '0;
        lane_wdata = {32'hCAFEF00D, 32'h0};
        lane_wstrb = {4'b0011, 4'hF};
        model_reset();
        @(negedge clk);
        settle();
        chk("reset.pause", pause_req, 1'b0);
        chk("reset.valid", dcache.dc_req_valid, 1'b0);
        adv();
        rst = 1'b0;

        // Vector table
        foreach (vq[i]) begin
            lane_valid = vq[i].lv; lane_we = vq[i].we;
            lane_addr[0] = vq[i].a0; lane_addr[1] = vq[i].a1;
            flush = vq[i].fl;
            dcache.dc_req_ready = vq[i].rdy;
            dcache.dc_resp_valid = vq[i].rv;
            dcache.dc_resp_rdata = vq[i].rd;
            settle();
            chk($sformatf("vec%0d.valid", i), dcache.dc_req_valid, vq[i].ev);
            chk($sformatf("vec%0d.addr", i),  dcache.dc_req_addr,  vq[i].ea);
            chk($sformatf("vec%0d.pause", i), pause_req,           vq[i].ep);
            chk($sformatf("vec%0d.done", i),  lane_done,           vq[i].ed);
            adv();
        end
        chk("vec.rdata0", lane_rdata[0], 32'h11111111);
        chk("vec.rdata1_kept", lane_rdata[1], 32'h13572468);
        idle_inputs();

        // Flush in WAIT0 with both lanes pending
        lane_we = 2'b00; lane_valid = 2'b11;
        tick();
        lane_valid = 2'b00; dcache.dc_req_ready = 1'b1;
        tick();
        dcache.dc_req_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("drain.pause", pause_req, 1'b1);
        chk("drain.valid", dcache.dc_req_valid, 1'b0);
        adv();
        dcache.dc_resp_valid = 1'b1; dcache.dc_resp_rdata = 32'h0BAD0BAD;
        tick();
        dcache.dc_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("drain.no_req1", dcache.dc_req_valid, 1'b0);
            chk("drain.no_done", lane_done, 2'b00);
            chk("drain.idle_pause", pause_req, 1'b0);
            adv();
        end
        chk("drain.rdata_kept", lane_rdata[0], 32'h11111111);

        // Flush in REQ0 with ready low
        lane_valid = 2'b01;
        tick();
        lane_valid = 2'b00; flush = 1'b1;
        settle();
        chk("reqflush.valid_before", dcache.dc_req_valid, 1'b1);
        adv();
        flush = 1'b0;
        settle();
        chk("reqflush.valid_after", dcache.dc_req_valid, 1'b0);
        chk("reqflush.pause_after", pause_req, 1'b0);
        adv();

        // Watchdog: response withheld for 6 WAIT cycles
        do_reset();
        lane_valid = 2'b01;
        tick();
        lane_valid = 2'b00; dcache.dc_req_ready = 1'b1;
        tick();
        dcache.dc_req_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("timeout.after%0d", i), timeout_err, (i >= TO));
        end
        dcache.dc_resp_valid = 1'b1; dcache.dc_resp_rdata = 32'h55AA55AA;
        tick();
        dcache.dc_resp_valid = 1'b0;
        tick();
        tick();
        chk("timeout.sticky", timeout_err, 1'b1);
        do_reset();
        chk("timeout.cleared", timeout_err, 1'b0);

        // Reset mid-operation, then a stray response
        lane_valid = 2'b11;
        tick();
        lane_valid = 2'b00; dcache.dc_req_ready = 1'b1;
        tick();
        dcache.dc_req_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        settle();
        chk("midrst.pause", pause_req, 1'b0);
        chk("midrst.rdata", lane_rdata, 64'h0);
        adv();
        rst = 1'b0;
        dcache.dc_resp_valid = 1'b1; dcache.dc_resp_rdata = 32'h99999999;
        tick();
        dcache.dc_resp_valid = 1'b0;
        tick();
        chk("midrst.stray_ignored", lane_rdata[0], 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst = (($urandom % 250) == 0);
            lane_valid = 2'($urandom);
            lane_we    = 2'($urandom);
            lane_addr  = {$urandom, $urandom};
            lane_wdata = {$urandom, $urandom};
            lane_wstrb = 8'($urandom);
            flush      = (($urandom % 12) == 0);
            dcache.dc_req_ready  = 1'($urandom);
            dcache.dc_resp_valid = (($urandom % 3) == 0);
            dcache.dc_resp_rdata = $urandom;
            if (rst) model_reset();
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
